seq_tx: RTL

Serial pattern transmitter: accepts parallel words over a valid/ready handshake and shifts each one out MSB-first on a single-bit line `out`, one bit per `clk`. It is the source side of the bit-serial link whose sink is the `fsm` sequence detector (`clk`, `in`, `out`). Its `out` drives the detector's `in` directly. A one-entry pending buffer allows back-to-back frames, with an optional fixed idle gap between them.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_pend_buf.sv | 42 ++++
 rtl/seq_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the bit-serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } seq_state_t;

  localparam logic SEQ_IDLE_LVL = 1'b0;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned seq_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_pend_buf.sv
// One-entry holding register for the word queued behind the frame in flight.
module seq_pend_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: parallel words in over valid/ready, MSB-first
// bit stream out, with a one-word pending buffer and optional inter-frame gap.
module seq_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);
  import seq_pkg::*;

  localparam int unsigned BCW    = seq_cnt_w(WIDTH);
  localparam int unsigned GCW    = seq_cnt_w(GAP + 1);
  localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_M1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [GCW-1:0]   gcnt_q, gcnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             frame_end;
  logic             pend_full;
  logic             pend_load;
  logic             pend_take;
  logic [WIDTH-1:0] pend_data;

  seq_pend_buf #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pend_load),
    .take (pend_take),
    .din  (data),
    .full (pend_full),
    .dout (pend_data)
  );

  assign ready  = !pend_full;
  assign accept = valid && ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    gcnt_d    = gcnt_q;
    done_d    = 1'b0;
    pend_load = 1'b0;
    pend_take = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      seq_pkg::IDLE: frame_end = 1'b1;
      seq_pkg::SHIFT: begin
        shreg_d = shreg_q << 1;
        bcnt_d  = bcnt_q - BCW'(1);
        if (bcnt_q == '0) begin
          done_d = 1'b1;
          if (GAP != 0) begin
            state_d   = seq_pkg::GAP;
            gcnt_d    = GAP_LAST;
            pend_load = accept;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          pend_load = accept;
        end
      end
      seq_pkg::GAP: begin
        if (gcnt_q == '0) begin
          frame_end = 1'b1;
        end else begin
          gcnt_d    = gcnt_q - GCW'(1);
          pend_load = accept;
        end
      end
      default: state_d = seq_pkg::IDLE;
    endcase

    // A word offered on a frame boundary with the buffer empty goes straight
    // into the shifter, so IDLE is never entered with a word pending.
    if (frame_end) begin
      if (pend_full || accept) begin
        shreg_d   = pend_full ? pend_data : data;
        pend_take = pend_full;
        bcnt_d    = BIT_LAST;
        state_d   = seq_pkg::SHIFT;
      end else begin
        state_d = seq_pkg::IDLE;
      end
    end

    out_d  = (state_d == seq_pkg::SHIFT) ? shreg_d[WIDTH-1] : SEQ_IDLE_LVL;
    busy_d = (state_d != seq_pkg::IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seq_pkg::IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      out_q   <= SEQ_IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
